// File: rtl/delay_fifo_ctrl_pkg.sv
// Shared types and helpers for the delay-buffer streaming controller.
package delay_fifo_ctrl_pkg;

  // Controller operating modes.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Width needed to hold a word count from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_fifo_ctrl_if.sv
// Bundle of stream, status and buffer-side signals around the controller.
// The slave modport is the controller's view; master is the surrounding system
// (producer, consumer and the attached shift buffer).
interface delay_fifo_ctrl_if
  import delay_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) ();

  localparam int CW = count_width(DEPTH);

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic            flush;
  logic            busy;
  logic [CW-1:0]   count;
  logic            buf_en;
  logic [BITS-1:0] buf_d;
  logic [BITS-1:0] buf_q;

  modport slave (
    input  in_valid, in_data, out_ready, flush, buf_q,
    output in_ready, out_valid, out_data, busy, count, buf_en, buf_d
  );

  modport master (
    output in_valid, in_data, out_ready, flush, buf_q,
    input  in_ready, out_valid, out_data, busy, count, buf_en, buf_d
  );

endinterface

// File: rtl/delay_fifo_ctrl_vld_tag_pipe.sv
// One-bit tag shift register running alongside the external data buffer.
// A set tag marks a stage holding a real word; index DEPTH-1 is the output.
module vld_tag_pipe #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tag_in,
  output logic [DEPTH-1:0] vld
);

  logic [DEPTH-1:0] vld_r;

  // Shift tags toward the output stage in lockstep with the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= '0;
    end else if (en) begin
      vld_r <= {vld_r[DEPTH-2:0], tag_in};
    end else begin
      vld_r <= vld_r;
    end
  end

  assign vld = vld_r;

endmodule

// File: rtl/delay_fifo_ctrl.sv
// Turns an external shift-on-enable delay buffer into a valid/ready stream
// element: owns the shift enable, tracks real words with a tag pipe, applies
// backpressure and drains the buffer with bubbles on flush.
module delay_fifo_ctrl
  import delay_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input logic              clk,
  input logic              rst,
  delay_fifo_ctrl_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic [DEPTH-1:0] vld_s;

  logic             flushing_s;
  logic             shift_ok_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_valid_s;
  logic             out_fire_s;
  logic             buf_en_s;
  logic             tag_in_s;
  logic [BITS-1:0]  buf_d_s;
  logic [CW-1:0]    count_nxt_s;

  // Handshake, shift enable and next-count derivation from registered state.
  always_comb begin
    flushing_s  = (state_r == FLUSH);
    // The buffer may shift unless a real word sits at the output unconsumed.
    shift_ok_s  = !vld_s[DEPTH-1] || bus.out_ready;
    in_ready_s  = !flushing_s && shift_ok_s;
    in_fire_s   = bus.in_valid && in_ready_s;
    // Offer the output only when a shift is pending, so an out fire is
    // always accompanied by buf_en and the word actually leaves the buffer.
    out_valid_s = vld_s[DEPTH-1] && ((bus.in_valid && !flushing_s) || flushing_s);
    out_fire_s  = out_valid_s && bus.out_ready;
    buf_en_s    = shift_ok_s && (in_fire_s || flushing_s);

    if (in_fire_s) begin
      buf_d_s  = bus.in_data;
      tag_in_s = 1'b1;
    end else begin
      buf_d_s  = {BITS{1'b0}};
      tag_in_s = 1'b0;
    end

    case ({in_fire_s, out_fire_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Mode FSM with registered word count and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= CNT_ZERO;
      busy_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      case (state_r)
        IDLE, RUN: begin
          if (count_nxt_s == CNT_ZERO) begin
            // Also covers a flush request while empty: nothing to drain.
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (bus.flush) begin
            state_r <= FLUSH;
            busy_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b0;
          end
        end
        FLUSH: begin
          if (count_nxt_s == CNT_ZERO) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= FLUSH;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  vld_tag_pipe #(
    .DEPTH (DEPTH)
  ) u_vld_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .en     (buf_en_s),
    .tag_in (tag_in_s),
    .vld    (vld_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = bus.buf_q;
  assign bus.busy      = busy_r;
  assign bus.count     = count_r;
  assign bus.buf_en    = buf_en_s;
  assign bus.buf_d     = buf_d_s;

endmodule

// File: tb/tb_delay_fifo_ctrl.sv
// Bench for delay_fifo_ctrl with DEPTH=4, BITS=8: an attached shift buffer,
// a slot/queue reference model, directed scenarios and randomized traffic.
module tb_delay_fifo_ctrl;
  import delay_fifo_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int BITS  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_fifo_ctrl_if #(.DEPTH(DEPTH), .BITS(BITS)) bus ();

  delay_fifo_ctrl #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Attached delay buffer: shift on enable, output at the last stage.
  logic [BITS-1:0] stage_r [DEPTH];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else if (bus.buf_en) begin
      stage_r[0] <= bus.buf_d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end
  assign bus.buf_q = stage_r[DEPTH-1];

  // Reference model: per-slot occupancy, a draining flag, and the ordered
  // list of accepted words still owed to the consumer.
  bit              mv [DEPTH];
  bit              mflush;
  logic [BITS-1:0] sb [$];
  logic [BITS-1:0] fired [$];

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic            obs_ir, obs_ov, obs_be;
  logic [BITS-1:0] obs_od;
  logic [2:0]      obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mcount();
    int c;
    c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(mv[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    mflush = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: drive at negedge, check combinational and registered
  // outputs against the model, advance the model at posedge.
  task automatic cycle(input logic iv, input logic [BITS-1:0] id,
                       input logic ordy, input logic fl);
    bit last_v, shift_ok, e_ir, e_ov, e_be, in_fire, out_fire;
    int c;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    last_v   = mv[DEPTH-1];
    shift_ok = !last_v || ordy;
    e_ir     = !mflush && shift_ok;
    e_ov     = last_v && (mflush || iv);
    in_fire  = iv && e_ir;
    out_fire = e_ov && ordy;
    e_be     = shift_ok && (in_fire || mflush);
    obs_ir   = bus.in_ready;
    obs_ov   = bus.out_valid;
    obs_be   = bus.buf_en;
    obs_od   = bus.out_data;
    obs_cnt  = bus.count;
    chk("in_ready", 32'(obs_ir), 32'(e_ir));
    chk("out_valid", 32'(obs_ov), 32'(e_ov));
    chk("buf_en", 32'(obs_be), 32'(e_be));
    chk("count", 32'(obs_cnt), 32'(mcount()));
    chk("busy", 32'(bus.busy), 32'(mflush));
    if (e_be) chk("buf_d", 32'(bus.buf_d), in_fire ? 32'(id) : 32'h0);
    if (out_fire) begin
      chk("out_data", 32'(obs_od), (sb.size() > 0) ? 32'(sb[0]) : 32'hDEAD);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (obs_ov && ordy) fired.push_back(obs_od);
    @(posedge clk);
    if (e_be) begin
      for (int i = DEPTH-1; i > 0; i--) mv[i] = mv[i-1];
      mv[0] = in_fire;
    end
    if (in_fire) sb.push_back(id);
    c = mcount();
    if (mflush) mflush = (c > 0);
    else        mflush = fl && (c > 0);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Asynchronous reset, checked while still asserted, released at negedge.
  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_buf_en", 32'(bus.buf_en), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_buf_d", 32'(bus.buf_d), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0; bus.flush = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Streaming: first word out on the 5th input cycle, then in order.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      if (i >= 5) begin
        chk("stream_ov", 32'(obs_ov), 32'h1);
        chk("stream_od", 32'(obs_od), 32'(i - 4));
        chk("stream_cnt", 32'(obs_cnt), 32'h4);
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle_cycles(5);
    chk("drain_count", 32'(bus.count), 32'h0);

    // Backpressure: full buffer with a stalled consumer freezes everything.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    cycle(1'b1, 8'h14, 1'b0, 1'b0);
    chk("bp_buf_en", 32'(obs_be), 32'h0);
    chk("bp_in_ready", 32'(obs_ir), 32'h0);
    chk("bp_count", 32'(obs_cnt), 32'h4);
    chk("bp_count_hold", 32'(bus.count), 32'h4);
    cycle(1'b1, 8'h14, 1'b1, 1'b0);
    chk("rel_ov", 32'(obs_ov), 32'h1);
    chk("rel_od", 32'(obs_od), 32'h10);
    chk("rel_be", 32'(obs_be), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle_cycles(5);

    // Partial flush of two words.
    cycle(1'b1, 8'hA0, 1'b1, 1'b0);
    cycle(1'b1, 8'hA1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("pf_busy", 32'(bus.busy), 32'h1);
    fired.delete();
    idle_cycles(4);
    chk("pf_nfired", 32'(fired.size()), 32'h2);
    chk("pf_first", (fired.size() > 0) ? 32'(fired[0]) : 32'hDEAD, 32'hA0);
    chk("pf_second", (fired.size() > 1) ? 32'(fired[1]) : 32'hDEAD, 32'hA1);
    chk("pf_count", 32'(bus.count), 32'h0);
    chk("pf_busy_end", 32'(bus.busy), 32'h0);
    chk("pf_idle", 32'(dut.state_r), 32'(IDLE));

    // Flush in the same cycle as an accepted word.
    cycle(1'b1, 8'hB0, 1'b1, 1'b1);
    chk("fi_accept", 32'(obs_ir), 32'h1);
    chk("fi_busy", 32'(bus.busy), 32'h1);
    fired.delete();
    cycle(1'b1, 8'hB1, 1'b1, 1'b0);
    chk("fi_block", 32'(obs_ir), 32'h0);
    idle_cycles(4);
    chk("fi_nfired", 32'(fired.size()), 32'h1);
    chk("fi_word", (fired.size() > 0) ? 32'(fired[0]) : 32'hDEAD, 32'hB0);
    chk("fi_count", 32'(bus.count), 32'h0);

    // Flush while empty is ignored.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("fe_buf_en", 32'(obs_be), 32'h0);
    chk("fe_busy", 32'(bus.busy), 32'h0);
    chk("fe_idle", 32'(dut.state_r), 32'(IDLE));

    // Randomized traffic with a reset dropped in mid-stream.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      if (n == 200) do_reset();
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle_cycles(6);
    chk("final_count", 32'(bus.count), 32'h0);
    chk("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
